// File: rtl/mem_pkg.sv
// Shared memory-port constants and initiator FSM states.
// Imported by the memory and the burst initiator.
package mem_pkg;

  localparam int MEM_DEPTH   = 16;
  localparam int MEM_WIDTH   = 32;
  localparam int MEM_TIMEOUT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Loadable down-counter; expired_o is high once it
// has counted down to zero.
module mem_timeout_ctr #(
  parameter int CYCLES = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // load arms the full window; en burns one cycle of it
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CW'(CYCLES - 1);
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/mem_burst_initiator.sv
// Burst command to single-beat valid/ready memory
// transactions, one outstanding, with read responses.
module mem_burst_initiator
  import mem_pkg::*;
#(
  parameter int DEPTH      = MEM_DEPTH,
  parameter int WIDTH      = MEM_WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = MEM_TIMEOUT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_len_i,
  input  logic [WIDTH-1:0]      cmd_seed_i,
  output logic                  mem_valid_o,
  output logic                  mem_wr_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WIDTH-1:0]      rsp_data_o,
  output logic                  rsp_last_o,
  output logic                  done_o,
  output logic                  err_o
);

  state_e state_q, state_d;

  logic                  rdy_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] beat_q;
  logic [WIDTH-1:0]      seed_q;
  logic [WIDTH-1:0]      rsp_q;
  logic                  done_q;
  logic                  err_q;
  logic                  expired;
  logic                  accept;
  logic                  last;
  logic [ADDR_WIDTH-1:0] addr_nx;

  assign accept  = cmd_valid_i && rdy_q;
  assign last    = (beat_q == len_q);
  assign addr_nx = (int'(addr_q) == DEPTH - 1)
                 ? '0 : addr_q + 1'b1;

  mem_timeout_ctr #(
    .CYCLES (TIMEOUT)
  ) u_tmo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (state_q == ST_ISSUE),
    .en_i      (state_q == ST_WAIT),
    .expired_o (expired)
  );

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_ready_i) begin
          if (!wr_q)     state_d = ST_RESP;
          else if (last) state_d = ST_IDLE;
          else           state_d = ST_ISSUE;
        end else if (expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = last ? ST_IDLE : ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // burst context, response capture and status pulses
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      seed_q  <= '0;
      rsp_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == ST_IDLE);
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            wr_q   <= cmd_wr_i;
            addr_q <= cmd_addr_i;
            len_q  <= cmd_len_i;
            seed_q <= cmd_seed_i;
            beat_q <= '0;
          end
        end
        ST_WAIT: begin
          if (mem_ready_i) begin
            if (!wr_q) begin
              rsp_q <= mem_rdata_i;
            end else if (last) begin
              done_q <= 1'b1;
            end else begin
              beat_q <= beat_q + 1'b1;
              addr_q <= addr_nx;
            end
          end else if (expired) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            if (last) begin
              done_q <= 1'b1;
            end else begin
              beat_q <= beat_q + 1'b1;
              addr_q <= addr_nx;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready_o = rdy_q;
  assign mem_valid_o = (state_q == ST_ISSUE);
  assign mem_wr_o    = wr_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = seed_q + WIDTH'(beat_q);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_data_o  = rsp_q;
  assign rsp_last_o  = (state_q == ST_RESP) && last;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Randomized bench for mem_burst_initiator against a
// burst-level memory model.
module tb_mem_burst_initiator;
  import mem_pkg::*;

  localparam int DEPTH   = 16;
  localparam int WIDTH   = 32;
  localparam int AW      = 4;
  localparam int TIMEOUT = 8;

  logic             clk_i = 0;
  logic             rst_i = 0;
  logic             cmd_valid_i = 0;
  logic             cmd_ready_o;
  logic             cmd_wr_i = 0;
  logic [AW-1:0]    cmd_addr_i = '0;
  logic [AW-1:0]    cmd_len_i = '0;
  logic [WIDTH-1:0] cmd_seed_i = '0;
  logic             mem_valid_o;
  logic             mem_wr_o;
  logic [AW-1:0]    mem_addr_o;
  logic [WIDTH-1:0] mem_wdata_o;
  logic             mem_ready_i;
  logic [WIDTH-1:0] mem_rdata_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i = 1;
  logic [WIDTH-1:0] rsp_data_o;
  logic             rsp_last_o;
  logic             done_o;
  logic             err_o;

  int errs = 0;
  int checks = 0;

  logic [WIDTH-1:0] mem_arr [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic             blk = 0;

  always #5 clk_i = ~clk_i;

  mem_burst_initiator #(
    .DEPTH   (DEPTH),
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_wr_i    (cmd_wr_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_len_i   (cmd_len_i),
    .cmd_seed_i  (cmd_seed_i),
    .mem_valid_o (mem_valid_o),
    .mem_wr_o    (mem_wr_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_last_o  (rsp_last_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  // attached memory: ready one cycle after valid, blk stalls it
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_ready_i <= 1'b0;
      mem_rdata_i <= '0;
    end else begin
      mem_ready_i <= mem_valid_o && !blk;
      if (mem_valid_o && !blk) begin
        if (mem_wr_o) mem_arr[mem_addr_o] <= mem_wdata_o;
        else          mem_rdata_i <= mem_arr[mem_addr_o];
      end
    end
  end

  function automatic logic [WIDTH+AW+AW+7:0] all_out();
    return {cmd_ready_o, mem_valid_o, mem_wr_o, mem_addr_o,
            mem_wdata_o[AW-1:0], rsp_valid_o, rsp_last_o,
            done_o, err_o, rsp_data_o | mem_wdata_o};
  endfunction

  task automatic issue_cmd(input logic wr, input logic [AW-1:0] a,
                           input logic [AW-1:0] l,
                           input logic [WIDTH-1:0] s);
    int n = 0;
    while (cmd_ready_o !== 1'b1 && n < 20) begin
      @(posedge clk_i); #1; n++;
    end
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      errs++;
      $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready_o);
    end
    cmd_valid_i = 1; cmd_wr_i = wr; cmd_addr_i = a;
    cmd_len_i = l; cmd_seed_i = s;
    @(posedge clk_i); #1;
    cmd_valid_i = 0;
  endtask

  task automatic run_burst(input logic wr, input logic [AW-1:0] a,
                           input logic [AW-1:0] l,
                           input logic [WIDTH-1:0] s,
                           input int stall_beat, input int stall_n,
                           input logic exp_err);
    logic [WIDTH-1:0] exp_d [DEPTH];
    logic [AW-1:0]    exp_a [DEPTH];
    int beats = int'(l) + 1;
    int pulses = 0, rbeats = 0, stall_left = 0;
    int done_cyc = -1, exp_cyc;
    bit stalled = 0;
    logic prev_v = 0, got_err = 0, got_rdy = 0;
    for (int i = 0; i < beats; i++) begin
      exp_a[i] = AW'((int'(a) + i) % DEPTH);
      exp_d[i] = wr ? s + WIDTH'(i) : ref_mem[exp_a[i]];
    end
    issue_cmd(wr, a, l, s);
    for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
      if (mem_valid_o) begin
        checks++;
        if (prev_v || pulses >= beats) begin
          errs++;
          $display("FAIL valid_pulse: pulse %0d prev %b", pulses, prev_v);
        end else if (mem_addr_o !== exp_a[pulses] || mem_wr_o !== wr ||
                     (wr && mem_wdata_o !== exp_d[pulses])) begin
          errs++;
          $display("FAIL issue_beat%0d: addr %0h wr %b wd %0h want %0h %b %0h",
                   pulses, mem_addr_o, mem_wr_o, mem_wdata_o,
                   exp_a[pulses], wr, exp_d[pulses]);
        end
        pulses++;
      end
      prev_v = mem_valid_o;
      if (rsp_valid_o) begin
        if (rbeats == stall_beat && !stalled) begin
          stalled = 1; stall_left = stall_n;
        end
        checks++;
        if (rbeats >= beats || rsp_data_o !== exp_d[rbeats] ||
            rsp_last_o !== (rbeats == beats - 1) || mem_valid_o) begin
          errs++;
          $display("FAIL rsp_beat%0d: data %0h last %b mv %b want %0h %b 0",
                   rbeats, rsp_data_o, rsp_last_o, mem_valid_o,
                   exp_d[rbeats % DEPTH], rbeats == beats - 1);
        end
        if (stall_left > 0) begin
          rsp_ready_i = 0; stall_left--;
        end else begin
          rsp_ready_i = 1; rbeats++;
        end
      end else begin
        rsp_ready_i = 1;
      end
      if (done_o) begin
        done_cyc = cyc; got_err = err_o; got_rdy = cmd_ready_o;
      end
      @(posedge clk_i); #1;
    end
    rsp_ready_i = 1;
    if (exp_err)  exp_cyc = TIMEOUT + 2;
    else if (wr)  exp_cyc = 2 * beats + 1;
    else          exp_cyc = 3 * beats + 1 +
                            ((stall_beat < beats) ? stall_n : 0);
    checks++;
    if (done_cyc != exp_cyc || got_err !== exp_err || got_rdy !== 1'b1) begin
      errs++;
      $display("FAIL done: cyc %0d err %b rdy %b want %0d %b 1",
               done_cyc, got_err, got_rdy, exp_cyc, exp_err);
    end
    checks++;
    if (pulses != (exp_err ? 1 : beats) ||
        rbeats != ((exp_err || wr) ? 0 : beats)) begin
      errs++;
      $display("FAIL beat_count: pulses %0d rsp %0d want %0d %0d",
               pulses, rbeats, exp_err ? 1 : beats,
               (exp_err || wr) ? 0 : beats);
    end
    if (wr && !exp_err) begin
      for (int i = 0; i < beats; i++) ref_mem[exp_a[i]] = exp_d[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (mem_arr[i] !== ref_mem[i]) begin
        errs++;
        $display("FAIL mem_word%0d: got %0h want %0h",
                 i, mem_arr[i], ref_mem[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (all_out() !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got %0h want 0", all_out());
    end
    rst_i = 1;
    @(posedge clk_i); #1;
    checks++;
    if (cmd_ready_o !== 1'b1 || mem_valid_o !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: rdy %b mv %b want 1 0",
               cmd_ready_o, mem_valid_o);
    end
  endtask

  task automatic test_directed();
    run_burst(1, 4'd3, 4'd3, 32'h100, 99, 0, 0);
    run_burst(0, 4'd3, 4'd3, 32'h0, 99, 0, 0);
    run_burst(1, 4'd14, 4'd3, 32'hA, 99, 0, 0);
    run_burst(1, 4'd15, 4'd0, 32'hFFFF_FFFF, 99, 0, 0);
  endtask

  task automatic test_backpressure();
    run_burst(0, 4'd14, 4'd3, 32'h0, 1, 5, 0);
  endtask

  task automatic test_timeout();
    blk = 1;
    run_burst(0, 4'd5, 4'd2, 32'h0, 99, 0, 1);
    blk = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      logic [AW-1:0] l = AW'($urandom_range(0, 15));
      run_burst(1'($urandom), AW'($urandom), l, $urandom,
                $urandom_range(0, int'(l)), $urandom_range(0, 3), 0);
    end
  endtask

  task automatic test_mid_reset();
    int seen = 0;
    issue_cmd(0, 4'd0, 4'd5, 32'h0);
    repeat (4) @(posedge clk_i);
    #2 rst_i = 0;
    #1;
    checks++;
    if (all_out() !== '0) begin
      errs++;
      $display("FAIL async_reset: got %0h want 0", all_out());
    end
    @(posedge clk_i); #1;
    rst_i = 1;
    repeat (4) begin
      @(posedge clk_i); #1;
      if (done_o || mem_valid_o || rsp_valid_o) seen++;
    end
    checks++;
    if (seen != 0) begin
      errs++;
      $display("FAIL post_reset_idle: active %0d want 0", seen);
    end
    run_burst(1, 4'd9, 4'd4, 32'h5A5A_0000, 99, 0, 0);
    run_burst(0, 4'd9, 4'd4, 32'h0, 99, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    test_reset();
    test_directed();
    test_backpressure();
    test_timeout();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
